adc_serial_responder: RTL and testbench
=======================================

Name: adc_serial_responder

Overview:
- Target-side model of the 12-bit serial ADC that the actuator controller (gestion_verin) reads through clk_adc / cs_n / data_in_adc.
- Shifts out a parallel value supplied by the host or testbench, in the MCP3201-style frame format the controller expects: sample period, null bit, MSB first.
- Used for hardware-in-the-loop on the board and as the bench responder for the controller.
- All pin inputs are treated as asynchronous: they are synchronized and edge-detected on the system clock.

Parameters:
- DATA_WIDTH, 12, number of conversion bits shifted out.
- SYNC_STAGES, 2, synchronizer flops on adc_clk and adc_cs_n (minimum 2).
- CNT_WIDTH, 16, width of frame_count.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- adc_value  in  DATA_WIDTH  value to convert, unsigned
- adc_clk  in  1  serial clock from the controller, asynchronous
- adc_cs_n  in  1  chip select from the controller, active-low, asynchronous
- adc_dout  out  1  serial data to the controller's data_in_adc
- adc_dout_oe  out  1  high while a frame is active (cs_n low); for a board tristate
- frame_done  out  1  one-clk pulse when the full frame (null + DATA_WIDTH bits) has been shifted
- frame_abort  out  1  one-clk pulse when cs_n rises before frame_done
- frame_count  out  CNT_WIDTH  count of completed frames, wraps at 2^CNT_WIDTH

Behaviour:
- Reset values (asynchronous): state IDLE, adc_dout=0, adc_dout_oe=0, frame_done=0, frame_abort=0, frame_count=0, synchronizers = idle level (clk 0, cs_n 1).
- Edge detection runs on the synchronized signals:
  - cs_fall / cs_rise on cs_n.
  - sclk_fall on adc_clk, qualified only while cs_n is synchronized low.
- Latency: an output change occurs exactly SYNC_STAGES+1 clk cycles after the pin edge.
- Supported input timing: adc_clk high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- Data is changed on sclk falling edges; the controller samples on rising edges.
- State machine:
  - IDLE: adc_dout=0, oe=0. On cs_fall, latch shreg<=adc_value, oe<=1, adc_dout<=0, go to SAMPLE.
  - SAMPLE: the first sclk_fall (sample/hold) is absorbed, adc_dout stays 0. The next sclk_fall drives the null bit 0 and goes to NULL.
  - NULL: on sclk_fall, adc_dout<=shreg[MSB], shift left, bitcnt<=DATA_WIDTH-1, go to SHIFT.
  - SHIFT: on each sclk_fall, if bitcnt>0 drive the next MSB and decrement. If bitcnt=0, adc_dout<=0, pulse frame_done, frame_count<=frame_count+1, go to TRAIL.
  - TRAIL: adc_dout=0. Further sclk_fall edges are ignored. Wait for cs_rise.
  - Any state other than IDLE: cs_rise → oe<=0, adc_dout<=0, go to IDLE.
    - frame_abort pulses only if the state was SAMPLE, NULL or SHIFT.
    - frame_done and frame_abort never pulse in the same cycle.
- Simultaneous cs_rise and sclk_fall in the same cycle: cs_rise wins, no bit is shifted, the abort rule applies.
- cs_fall while not IDLE is impossible: cs_rise always returns the FSM to IDLE first.
- adc_value changes after the cs_fall latch do not affect the frame in progress.
- sclk edges while cs_n is high are ignored entirely.
- frame_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-frame: immediate return to reset values. The frame in progress is neither counted nor flagged as aborted.
  - After reset is released with cs_n still low, wait for a cs_rise before accepting a frame, since no cs_fall has been seen.

Test Plan:
- Nominal frame:
  - Stimulus: adc_value=12'hA5C, sclk period 50 clk, cs_n low, 15 sclk cycles, cs_n high.
  - Required: bits sampled on rising edges 2..14 are 0,1010_0101_1100; frame_done pulses once; frame_count=1; oe high only between cs edges.
- Boundary values:
  - Stimulus: adc_value=12'h000 and 12'hFFF, each in its own frame.
  - Required: serial words 0x000 and 0xFFF; frame_count=2.
- Value change mid-frame:
  - Stimulus: adc_value 12'h123 at cs_fall, changed to 12'hEDC after 4 sclk.
  - Required: shifted word is 0x123.
- Abort:
  - Stimulus: cs_n rises after 6 sclk.
  - Required: frame_abort pulses once, frame_done stays 0, frame_count unchanged, adc_dout=0 and oe=0 four clk after the rise.
  - Then a full frame with 12'h800 reads correctly.
- Reset mid-SHIFT:
  - Stimulus: reset asserted mid-SHIFT, cs_n held low.
  - Required: all outputs 0 immediately; no response until cs_n toggles high then low; the next frame is correct.
- Wrap (CNT_WIDTH=2):
  - Stimulus: 5 complete frames.
  - Required: frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/adc_serial_responder.sv
// Target-side model of a 12-bit MCP3201-style serial ADC: shifts out a latched
// parallel value on falling edges of the controller's asynchronous serial clock.
module adc_serial_responder #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] adc_value,
    input  logic                  adc_clk,
    input  logic                  adc_cs_n,
    output logic                  adc_dout,
    output logic                  adc_dout_oe,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_NULL   = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_TRAIL  = 3'd4;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic [SYNC_STAGES:0]   fill_q;

    logic [2:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic                   held_q, held_d;
    logic                   dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic cs_s, sclk_s, fill_done;
    logic cs_fall, cs_rise, sclk_fall;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    // Edges are only trusted once every sync/prev flop holds a real pin sample,
    // so a cs_n held low across reset never looks like a fresh cs_fall.
    assign fill_done = fill_q[SYNC_STAGES];
    assign cs_fall   = fill_done &  cs_prev_q & ~cs_s;
    assign cs_rise   = fill_done & ~cs_prev_q &  cs_s;
    assign sclk_fall = fill_done &  sclk_prev_q & ~sclk_s & ~cs_s;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        held_d   = held_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        count_d  = count_q;

        if (state_q == ST_IDLE) begin
            dout_d = 1'b0;
            oe_d   = 1'b0;
            if (cs_fall) begin
                shreg_d = adc_value;
                held_d  = 1'b0;
                oe_d    = 1'b1;
                state_d = ST_SAMPLE;
            end
        end else if (cs_rise) begin
            oe_d    = 1'b0;
            dout_d  = 1'b0;
            state_d = ST_IDLE;
            abort_d = (state_q == ST_SAMPLE) || (state_q == ST_NULL) ||
                      (state_q == ST_SHIFT);
        end else if (sclk_fall) begin
            case (state_q)
                ST_SAMPLE: begin
                    if (!held_q) begin
                        held_d = 1'b1;
                    end else begin
                        dout_d  = 1'b0;
                        state_d = ST_NULL;
                    end
                end
                ST_NULL: begin
                    dout_d   = shreg_q[DATA_WIDTH-1];
                    shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    bitcnt_d = BW'(DATA_WIDTH - 1);
                    state_d  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bitcnt_q != '0) begin
                        dout_d   = shreg_q[DATA_WIDTH-1];
                        shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        bitcnt_d = bitcnt_q - BW'(1);
                    end else begin
                        dout_d  = 1'b0;
                        done_d  = 1'b1;
                        count_d = count_q + CNT_WIDTH'(1);
                        state_d = ST_TRAIL;
                    end
                end
                ST_TRAIL: ;
                default: begin
                    dout_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q > ST_TRAIL) begin
            dout_d  = 1'b0;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            fill_q      <= '0;
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            held_q      <= 1'b0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_clk};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            held_q      <= held_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            count_q     <= count_d;
        end
    end

    assign adc_dout    = dout_q;
    assign adc_dout_oe = oe_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drives controller-style frames and
// checks the serial word, pulses, output enable and frame counter.
module tb_adc_serial_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] adc_value = '0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;

    logic        dout_a, oe_a, done_a, abort_a;
    logic [15:0] cnt_a;
    logic        dout_b, oe_b, done_b, abort_b;
    logic [1:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_both = 0;

    adc_serial_responder u_dut (
        .clk(clk), .reset(reset), .adc_value(adc_value), .adc_clk(sclk),
        .adc_cs_n(cs_n), .adc_dout(dout_a), .adc_dout_oe(oe_a),
        .frame_done(done_a), .frame_abort(abort_a), .frame_count(cnt_a)
    );

    adc_serial_responder #(.CNT_WIDTH(2)) u_wrap (
        .clk(clk), .reset(reset), .adc_value(adc_value), .adc_clk(sclk),
        .adc_cs_n(cs_n), .adc_dout(dout_b), .adc_dout_oe(oe_b),
        .frame_done(done_b), .frame_abort(abort_b), .frame_count(cnt_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (done_a) n_done++;
        if (abort_a) n_abort++;
        if (done_a && abort_a) n_both++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One chip-select frame of ncyc serial clocks; samples dout just before each rise.
    task automatic do_frame(input logic [11:0] val, input int ncyc, input int chg_at,
                            input logic [11:0] chg_val, output logic [11:0] word,
                            output logic [2:0] pre, output logic oe_mid, output logic oe_pre);
        logic [14:0] s;
        s = '0;
        oe_mid = 1'b0;
        adc_value = val;
        oe_pre = oe_a;
        cs_n = 1'b0;
        tick(10);
        for (int k = 0; k < ncyc; k++) begin
            if (k < 15) s[14-k] = dout_a;
            if (k == 5) oe_mid = oe_a;
            if (k == chg_at) adc_value = chg_val;
            sclk = 1'b1;
            tick(25);
            sclk = 1'b0;
            tick(25);
        end
        pre  = s[14:12];
        word = s[11:0];
        tick(10);
        cs_n = 1'b1;
        tick(4);
        check_eq("post_rise_oe", oe_a, 0);
        check_eq("post_rise_dout", dout_a, 0);
        tick(10);
    endtask

    initial begin
        logic [11:0] word;
        logic [2:0]  pre;
        logic        oe_mid, oe_pre;
        int          d0, a0, quiet;
        int          exp_cnt;
        logic [11:0] vals [5];
        logic [1:0]  wrap_exp [5];
        vals     = '{12'h001, 12'h7FE, 12'hC3A, 12'h456, 12'hBEE};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_cnt  = 0;

        tick(5);
        check_eq("rst_dout", dout_a, 0);
        check_eq("rst_oe", oe_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_abort", abort_a, 0);
        check_eq("rst_count", cnt_a, 0);
        reset = 1'b0;
        tick(10);

        // Nominal frame
        d0 = n_done; a0 = n_abort;
        do_frame(12'hA5C, 15, -1, '0, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("nom_word", word, 12'hA5C);
        check_eq("nom_lead_zeros", pre, 0);
        check_eq("nom_oe_before", oe_pre, 0);
        check_eq("nom_oe_mid", oe_mid, 1);
        check_eq("nom_done_pulses", n_done - d0, 1);
        check_eq("nom_abort_pulses", n_abort - a0, 0);
        check_eq("nom_count", cnt_a, exp_cnt);

        // Boundary values
        do_frame(12'h000, 15, -1, '0, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("zero_word", word, 12'h000);
        do_frame(12'hFFF, 15, -1, '0, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("ones_word", word, 12'hFFF);
        check_eq("ones_lead_zeros", pre, 0);
        check_eq("boundary_count", cnt_a, exp_cnt);

        // Value change mid-frame
        do_frame(12'h123, 15, 4, 12'hEDC, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("latch_word", word, 12'h123);

        // Abort after 6 serial clocks
        d0 = n_done; a0 = n_abort;
        do_frame(12'h5A5, 6, -1, '0, word, pre, oe_mid, oe_pre);
        check_eq("abort_pulses", n_abort - a0, 1);
        check_eq("abort_no_done", n_done - d0, 0);
        check_eq("abort_count", cnt_a, exp_cnt);
        do_frame(12'h800, 15, -1, '0, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("after_abort_word", word, 12'h800);
        check_eq("after_abort_count", cnt_a, exp_cnt);

        // Reset mid-SHIFT with cs_n held low
        adc_value = 12'h3C3;
        cs_n = 1'b0;
        tick(10);
        for (int k = 0; k < 8; k++) begin
            sclk = 1'b1; tick(25); sclk = 1'b0; tick(25);
        end
        d0 = n_done; a0 = n_abort;
        reset = 1'b1;
        #1;
        check_eq("midrst_dout", dout_a, 0);
        check_eq("midrst_oe", oe_a, 0);
        check_eq("midrst_done", done_a, 0);
        check_eq("midrst_abort", abort_a, 0);
        check_eq("midrst_count", cnt_a, 0);
        tick(3);
        reset = 1'b0;
        exp_cnt = 0;
        tick(10);
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            sclk = 1'b1; tick(25);
            if (oe_a || dout_a) quiet++;
            sclk = 1'b0; tick(25);
            if (oe_a || dout_a) quiet++;
        end
        check_eq("midrst_quiet", quiet, 0);
        check_eq("midrst_no_pulses", (n_done - d0) + (n_abort - a0), 0);
        cs_n = 1'b1;
        tick(10);
        do_frame(12'h5A3, 15, -1, '0, word, pre, oe_mid, oe_pre);
        exp_cnt++;
        check_eq("midrst_next_word", word, 12'h5A3);
        check_eq("midrst_next_count", cnt_a, exp_cnt);

        // Counter wrap on the 2-bit instance
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        for (int i = 0; i < 5; i++) begin
            do_frame(vals[i], 15, -1, '0, word, pre, oe_mid, oe_pre);
            check_eq("wrap_word", word, vals[i]);
            check_eq("wrap_count", cnt_b, wrap_exp[i]);
        end

        check_eq("done_abort_overlap", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
